// File: rtl/filter_out_quantizer.sv
// Rounds and saturates the filter's wide accumulator output to an OUT_W-bit sample.
// It is a two-stage elastic pipeline with valid/ready on both sides and saturation statistics.
module filter_out_quantizer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] sat_count,
    output logic             sat_flag
);

    localparam int EXT_W = IN_W + 1;

    localparam logic signed [EXT_W-1:0] ONE    = EXT_W'(1);
    localparam logic signed [EXT_W-1:0] HALF   = ONE << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] SAT_HI = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_LO = ~SAT_HI;
    localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic                    s1_valid_q;
    logic signed [EXT_W-1:0] s1_r_q;
    logic signed [EXT_W-1:0] s1_r_d;
    logic                    s2_valid_q;
    logic [OUT_W-1:0]        s2_data_q;
    logic [OUT_W-1:0]        s2_data_d;
    logic                    s2_sat_q;
    logic                    s2_sat_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    flag_q;
    logic                    flag_d;

    logic signed [EXT_W-1:0] in_ext;
    logic                    s1_load;
    logic                    s2_load;
    logic                    sat_xfer;

    // One guard bit keeps the rounding add from overflowing for any input.
    assign in_ext = {in_data[IN_W-1], in_data};
    assign s1_r_d = (in_ext + HALF) >>> SHIFT;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        s2_data_d = s1_r_q[OUT_W-1:0];
        s2_sat_d  = 1'b0;
        if (s1_r_q > SAT_HI) begin
            s2_data_d = OUT_MAX;
            s2_sat_d  = 1'b1;
        end else if (s1_r_q < SAT_LO) begin
            s2_data_d = OUT_MIN;
            s2_sat_d  = 1'b1;
        end
    end

    assign sat_xfer = s2_valid_q && out_ready && s2_sat_q;

    // A clear coinciding with a saturating transfer counts that transfer.
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (clr_stats) begin
            cnt_d  = sat_xfer ? CNT_W'(1) : '0;
            flag_d = sat_xfer;
        end else if (sat_xfer) begin
            flag_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
            cnt_q      <= '0;
            flag_q     <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_r_q <= s1_r_d;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s2_data_d;
                    s2_sat_q  <= s2_sat_d;
                end
            end
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign out_data  = s2_data_q;
    assign out_valid = s2_valid_q;
    assign sat_count = cnt_q;
    assign sat_flag  = flag_q;

endmodule

// File: tb/tb_filter_out_quantizer.sv
// Bench for filter_out_quantizer: directed vector table, hand-written corner sequences,
// and a random stream scored against an arithmetic round/saturate model.
module tb_filter_out_quantizer;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        clr_stats;
    logic [15:0] sat_count;
    logic        sat_flag;

    filter_out_quantizer #(.IN_W(32), .OUT_W(16), .SHIFT(15), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_stats (clr_stats),
        .sat_count (sat_count),
        .sat_flag  (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;

    logic [16:0] exp_q[$];
    int          exp_cnt  = 0;
    logic        exp_flag = 1'b0;
    logic        o_fire;
    logic        o_sat;
    logic [16:0] e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: {sat, sample} from floor((x + 2^14) / 2^15), clamped to int16.
    function automatic logic [16:0] model(input logic [31:0] x);
        longint v;
        logic [63:0] u;
        v = longint'(signed'(x)) + 64'sd16384;
        v = v >>> 15;
        if (v > 64'sd32767)  return {1'b1, 16'h7FFF};
        if (v < -64'sd32768) return {1'b1, 16'h8000};
        u = 64'(v);
        return {1'b0, u[15:0]};
    endfunction

    // Scoreboard and statistics model, sampled mid-cycle when inputs are stable.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            exp_cnt  = 0;
            exp_flag = 1'b0;
        end else begin
            chk("sat_count", 32'(sat_count), 32'(exp_cnt));
            chk("sat_flag", 32'(sat_flag), 32'(exp_flag));
            o_fire = out_valid && out_ready;
            o_sat  = 1'b0;
            if (o_fire) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[15:0]));
                    o_sat = e[16];
                    n_out++;
                end
            end
            if (clr_stats) begin
                exp_cnt  = (o_fire && o_sat) ? 1 : 0;
                exp_flag = o_fire && o_sat;
            end else if (o_fire && o_sat) begin
                exp_flag = 1'b1;
                if (exp_cnt < 65535) exp_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle(input logic v, input logic [31:0] d, input logic ordy,
                               input logic clr, output logic fired);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr_stats = clr;
        #1;
        fired = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] din;
        logic [15:0] dout;
        logic        sat;
    } vec_t;

    initial begin
        vec_t        tab[8];
        logic [31:0] bp_vec[8];
        logic        fired;
        logic [15:0] held;
        logic [16:0] r;
        int          tab_cnt;
        int          sent;
        int          cyc;
        int          stall;
        logic        v;
        logic        ordy;
        logic        clr;
        logic [31:0] d;

        tab[0] = '{32'h0000_4000, 16'h0001, 1'b0};
        tab[1] = '{32'h0000_3FFF, 16'h0000, 1'b0};
        tab[2] = '{32'hFFFF_C000, 16'h0000, 1'b0};
        tab[3] = '{32'hFFFF_BFFF, 16'hFFFF, 1'b0};
        tab[4] = '{32'h3FFF_8000, 16'h7FFF, 1'b0};
        tab[5] = '{32'h3FFF_C000, 16'h7FFF, 1'b1};
        tab[6] = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
        tab[7] = '{32'h8000_0000, 16'h8000, 1'b1};
        for (int i = 0; i < 8; i++) bp_vec[i] = 32'((i + 1) * 32'h0001_8000);

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        clr_stats = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        tick();
        tick();
        #2 rst = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        chk("rst_sat_flag", 32'(sat_flag), 32'd0);

        // Rounding and saturation table, one sample at a time, latency exact.
        tab_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = tab[i].din;
            #1;
            chk("tab_in_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            in_data  = $urandom;
            chk("tab_lat1_valid", 32'(out_valid), 32'd0);
            tick();
            chk("tab_lat2_valid", 32'(out_valid), 32'd1);
            chk("tab_out_data", 32'(out_data), 32'(tab[i].dout));
            tick();
            tab_cnt += int'(tab[i].sat);
            chk("tab_sat_count", 32'(sat_count), 32'(tab_cnt));
            chk("tab_after_valid", 32'(out_valid), 32'd0);
        end
        chk("tab_final_count", 32'(sat_count), 32'd3);
        chk("tab_final_flag", 32'(sat_flag), 32'd1);

        // Back-pressure: stall output for 5 cycles once the first sample emerges.
        sent  = 0;
        n_out = 0;
        cyc   = 0;
        stall = -1;
        held  = '0;
        while ((sent < 8 || n_out < 8) && cyc < 60) begin
            if (stall < 0 && out_valid) begin
                stall = 5;
                held  = out_data;
            end
            out_ready = !(stall > 0);
            in_valid  = (sent < 8);
            in_data   = bp_vec[sent % 8];
            #1;
            if (stall > 0) begin
                chk("bp_hold_data", 32'(out_data), 32'(held));
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                stall--;
            end
            fired = in_valid && in_ready;
            tick();
            if (fired) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_sent", 32'(sent), 32'd8);
        chk("bp_received", 32'(n_out), 32'd8);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Statistics: drive the counter past its ceiling.
        sent = 0;
        cyc  = 0;
        while (sent < 65539 && cyc < 70000) begin
            drive_cycle(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, fired);
            if (fired) sent++;
            cyc++;
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, fired);
        chk("stat_preset_count", 32'(sat_count), 32'h0000_FFFF);
        chk("stat_preset_flag", 32'(sat_flag), 32'd1);

        drive_cycle(1'b0, 32'h0, 1'b1, 1'b1, fired);
        clr_stats = 1'b0;
        chk("stat_clr_count", 32'(sat_count), 32'd0);
        chk("stat_clr_flag", 32'(sat_flag), 32'd0);

        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0, fired);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, fired);
        chk("stat_pre_coinc", 32'(sat_count), 32'd2);
        chk("stat_coinc_valid", 32'(out_valid), 32'd1);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b1, fired);
        clr_stats = 1'b0;
        chk("stat_coinc_count", 32'(sat_count), 32'd1);
        chk("stat_coinc_flag", 32'(sat_flag), 32'd1);

        // Reset with both stages full and statistics nonzero.
        drive_cycle(1'b1, 32'h7FFF_0000, 1'b0, 1'b0, fired);
        drive_cycle(1'b1, 32'h8000_1234, 1'b0, 1'b0, fired);
        in_valid = 1'b0;
        chk("mid_full_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_sat_count", 32'(sat_count), 32'd0);
        chk("mid_rst_sat_flag", 32'(sat_flag), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        r = model(32'h1234_5678);
        drive_cycle(1'b1, 32'h1234_5678, 1'b1, 1'b0, fired);
        in_valid = 1'b0;
        chk("mid_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("mid_lat2_valid", 32'(out_valid), 32'd1);
        chk("mid_out_data", 32'(out_data), 32'(r[15:0]));
        tick();

        // Random stream against the reference model.
        sent  = 0;
        n_out = 0;
        cyc   = 0;
        while (sent < 1000 && cyc < 20000) begin
            v    = ($urandom % 10) < 7;
            ordy = ($urandom % 10) < 6;
            clr  = ($urandom % 64) == 0;
            case ($urandom % 4)
                0: d = $urandom;
                1: d = 32'($urandom_range(0, 131071)) - 32'd65536;
                2: d = 32'h3FFF_C000 + 32'($urandom_range(0, 65535)) - 32'd32768;
                default: d = 32'hBFFF_C000 + 32'($urandom_range(0, 65535)) - 32'd32768;
            endcase
            drive_cycle(v, d, ordy, clr, fired);
            if (fired) sent++;
            cyc++;
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            drive_cycle(1'b0, $urandom, 1'b1, 1'b0, fired);
            cyc++;
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0, fired);
        chk("rand_sent", 32'(sent), 32'd1000);
        chk("rand_received", 32'(n_out), 32'd1000);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_idle_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
